// File: rtl/icache.sv
// ============================================================================
// icache -- direct-mapped instruction cache between fetcher and memory controller
//
// Purpose
//   Serves fetcher PC lookups from a direct-mapped array holding one
//   instruction (16-bit or 32-bit, as returned by the memory controller) per
//   line. A hit returns the instruction one cycle after the lookup. A miss
//   issues a single fetch to the memory controller, waits for the matching
//   returned instruction, fills the line and forwards the instruction.
//
//   Line index = pc[INDEX_WIDTH:1], tag = pc[XLEN-1:INDEX_WIDTH+1].
//
// Configuration
//   ICACHE_PERF_EN : when defined, adds 32-bit hit/miss counters
//                    (icache_hit_cnt, icache_miss_cnt). The default build
//                    leaves the macro undefined and has no counter ports.
//
// Ports
//   clk                in   1     clock
//   rst                in   1     synchronous reset, active-low
//   rdy                in   1     global enable; all state frozen when low
//   flush              in   1     pipeline flush, abandons any miss in progress
//   fet_icache_enable  in   1     fetcher lookup request
//   fet_icache_pc      in   XLEN  lookup PC
//   icache_fet_ready   out  1     one-cycle pulse: instruction valid
//   icache_fet_inst    out  XLEN  instruction (0 when not ready)
//   icache_fet_pc      out  XLEN  PC of icache_fet_inst
//   icache_fet_busy    out  1     miss in progress; fetcher must not issue
//   icache_mem_enable  out  1     one-cycle fetch request to memory controller
//   icache_mem_pc      out  XLEN  fetch address
//   mem_fet_busy       in   1     memory controller cannot accept a request
//   mem_inst_ready     in   1     memory controller instruction valid
//   mem_inst           in   XLEN  returned instruction
//   mem_inst_addr      in   XLEN  address of returned instruction
//   icache_hit_cnt     out  32    (ICACHE_PERF_EN only) lookups that hit
//   icache_miss_cnt    out  32    (ICACHE_PERF_EN only) lookups that missed
// ============================================================================
module icache #(
    parameter int XLEN        = 32,
    parameter int INDEX_WIDTH = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rdy,
    input  logic            flush,
    input  logic            fet_icache_enable,
    input  logic [XLEN-1:0] fet_icache_pc,
    output logic            icache_fet_ready,
    output logic [XLEN-1:0] icache_fet_inst,
    output logic [XLEN-1:0] icache_fet_pc,
    output logic            icache_fet_busy,
    output logic            icache_mem_enable,
    output logic [XLEN-1:0] icache_mem_pc,
    input  logic            mem_fet_busy,
    input  logic            mem_inst_ready,
    input  logic [XLEN-1:0] mem_inst,
    input  logic [XLEN-1:0] mem_inst_addr
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0]     icache_hit_cnt,
    output logic [31:0]     icache_miss_cnt
`endif
);

    localparam int LINES     = 1 << INDEX_WIDTH;
    localparam int TAG_WIDTH = XLEN - INDEX_WIDTH - 1;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_MISS_REQ  = 2'd1,
        S_MISS_WAIT = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                r_state;
    logic [XLEN-1:0]       r_pend_pc;
    logic [LINES-1:0]      r_valid;
    logic [TAG_WIDTH-1:0]  r_tag  [LINES];
    logic [XLEN-1:0]       r_data [LINES];

    logic                  r_fet_ready;
    logic [XLEN-1:0]       r_fet_inst;
    logic [XLEN-1:0]       r_fet_pc;
    logic                  r_mem_enable;
    logic [XLEN-1:0]       r_mem_pc;

`ifdef ICACHE_PERF_EN
    logic [31:0]           r_hit_cnt;
    logic [31:0]           r_miss_cnt;
`endif

    // ------------------------------------------------------------------
    // Lookup and fill decode
    // ------------------------------------------------------------------
    logic [INDEX_WIDTH-1:0] w_idx;
    logic [TAG_WIDTH-1:0]   w_tag;
    logic                   w_hit;
    logic [INDEX_WIDTH-1:0] w_fill_idx;
    logic [TAG_WIDTH-1:0]   w_fill_tag;
    logic                   w_fill;
    logic                   w_fill_we;
    logic                   w_unused;

    assign w_idx = fet_icache_pc[INDEX_WIDTH:1];
    assign w_tag = fet_icache_pc[XLEN-1:INDEX_WIDTH+1];
    assign w_hit = r_valid[w_idx] && (r_tag[w_idx] == w_tag);

    assign w_fill_idx = r_pend_pc[INDEX_WIDTH:1];
    assign w_fill_tag = r_pend_pc[XLEN-1:INDEX_WIDTH+1];

    // Only a return whose address matches the outstanding miss fills the line;
    // stray returns for other addresses are ignored.
    assign w_fill = (r_state == S_MISS_WAIT) && mem_inst_ready &&
                    (mem_inst_addr == r_pend_pc);

    // The array write must obey exactly the same priority as the control
    // block: frozen by rdy, dropped by reset, discarded by flush.
    assign w_fill_we = rdy && rst && !flush && w_fill;

    // Instructions are at least halfword aligned, so pc bit 0 takes no part
    // in index or tag.
    assign w_unused = fet_icache_pc[0];

    assign icache_fet_busy = (r_state != S_IDLE);

    // ------------------------------------------------------------------
    // Tag and data arrays
    // ------------------------------------------------------------------
    // NOTE: the arrays deliberately have no reset branch; the valid bits alone
    // decide whether a line is usable, and keeping the reset out of this block
    // lets it map onto plain RAM/register-file cells.
    always_ff @(posedge clk) begin
        if (w_fill_we) begin
            r_tag[w_fill_idx]  <= w_fill_tag;
            r_data[w_fill_idx] <= mem_inst;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    // NOTE: every register in this block uses non-blocking assignment so all
    // right-hand sides see pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rdy) begin
            if (!rst) begin
                r_state      <= S_IDLE;
                r_pend_pc    <= '0;
                r_valid      <= '0;
                r_fet_ready  <= 1'b0;
                r_fet_inst   <= '0;
                r_fet_pc     <= '0;
                r_mem_enable <= 1'b0;
                r_mem_pc     <= '0;
`ifdef ICACHE_PERF_EN
                r_hit_cnt    <= '0;
                r_miss_cnt   <= '0;
`endif
            end else if (flush) begin
                // Valid bits, PCs and counters are kept; only the transaction
                // in progress and the pulses are dropped.
                r_state      <= S_IDLE;
                r_fet_ready  <= 1'b0;
                r_fet_inst   <= '0;
                r_mem_enable <= 1'b0;
            end else begin
                // Pulse outputs default low; a branch below raises them.
                r_fet_ready  <= 1'b0;
                r_fet_inst   <= '0;
                r_mem_enable <= 1'b0;

                case (r_state)
                    S_IDLE: begin
                        if (fet_icache_enable) begin
                            if (w_hit) begin
                                r_fet_ready <= 1'b1;
                                r_fet_inst  <= r_data[w_idx];
                                r_fet_pc    <= fet_icache_pc;
`ifdef ICACHE_PERF_EN
                                r_hit_cnt   <= r_hit_cnt + 32'd1;
`endif
                            end else begin
                                r_pend_pc   <= fet_icache_pc;
                                r_state     <= S_MISS_REQ;
`ifdef ICACHE_PERF_EN
                                r_miss_cnt  <= r_miss_cnt + 32'd1;
`endif
                            end
                        end
                    end

                    S_MISS_REQ: begin
                        if (!mem_fet_busy) begin
                            r_mem_enable <= 1'b1;
                            r_mem_pc     <= r_pend_pc;
                            r_state      <= S_MISS_WAIT;
                        end
                    end

                    S_MISS_WAIT: begin
                        // Leaving for IDLE here makes a held-high ready
                        // count as a single return.
                        if (w_fill) begin
                            r_valid[w_fill_idx] <= 1'b1;
                            r_fet_ready         <= 1'b1;
                            r_fet_inst          <= mem_inst;
                            r_fet_pc            <= r_pend_pc;
                            r_state             <= S_IDLE;
                        end
                    end

                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign icache_fet_ready  = r_fet_ready;
    assign icache_fet_inst   = r_fet_inst;
    assign icache_fet_pc     = r_fet_pc;
    assign icache_mem_enable = r_mem_enable;
    assign icache_mem_pc     = r_mem_pc;

`ifdef ICACHE_PERF_EN
    assign icache_hit_cnt  = r_hit_cnt;
    assign icache_miss_cnt = r_miss_cnt;
`endif

endmodule
